ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide sequencer for the EX stage; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and services MFHI, MFLO, MTHI and MTLO.
- Sits beside the EX-stage ALU and receives the same forwarded operands.
- Raises a stall request to the hazard unit while busy, so the single-cycle ALU path never waits on it.

Parameters:
- NB_DATA, 32, operand, HI and LO width.
- NB_FUNCT, 6, width of the R-type funct field.
- NB_COUNT, 6, iteration counter width; must satisfy 2^NB_COUNT > NB_DATA.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  EX holds an instruction that targets this unit.
- i_funct  in  NB_FUNCT  funct code of that instruction.
- i_operand_A  in  NB_DATA  rs value, after forwarding.
- i_operand_B  in  NB_DATA  rt value, after forwarding.
- i_flush  in  1  abort the in-flight op (branch/jump flush).
- o_stall  out  1  hold IF/ID/EX this cycle.
- o_busy  out  1  iterative op in progress.
- o_done  out  1  one-cycle pulse when HI/LO were just updated by MULT/DIV.
- o_mf_result  out  NB_DATA  HI for MFHI, LO for MFLO, 0 otherwise.
- o_hi  out  NB_DATA  current HI register.
- o_lo  out  NB_DATA  current LO register.

Behaviour:
- Reset: state IDLE; HI, LO and counter = 0; o_busy, o_done and o_stall = 0.
- Funct codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - Any other funct with i_valid is ignored.
- FSM states: IDLE, CALC, FIX.
- IDLE + i_valid + mul/div funct, no flush:
  - Latch operands.
  - For signed ops, latch magnitudes plus result-sign flags: quotient sign = signA^signB, remainder sign = signA.
  - Counter := NB_DATA-1; go to CALC.
  - o_stall = 0 on the accept cycle, since the instruction proceeds down the pipe.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 2*NB_DATA product.
  - Divide: restoring algorithm, one quotient bit per cycle.
  - At counter 0, go to FIX.
- FIX: apply two's-complement sign correction, write HI/LO, and return to IDLE.
  - o_done = 1 in the cycle after FIX.
- Latency: accept at edge 0 → HI/LO valid after edge NB_DATA+1 (33 for default). o_busy is high for exactly NB_DATA+1 cycles.
- HI/LO mapping:
  - MULT/MULTU: HI = product[2N-1:N], LO = product[N-1:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (detected at accept): LO = all ones, HI = dividend. Still takes full latency; no exception.
- Signed overflow, 0x80000000 / -1: LO = 0x80000000, HI = 0.
- o_stall = i_valid & o_busy & (funct is any of the 8 unit codes). This covers a new mul/div, MF*, or MT* issued while busy; a stalled instruction is re-presented until it is accepted.
- MFHI/MFLO when not busy: o_mf_result is combinational from the current HI/LO, so it is same-cycle.
- MTHI/MTLO when not busy: HI or LO := i_operand_A at the next edge.
- i_flush:
  - In CALC/FIX: abort, go to IDLE next edge, HI/LO unchanged, no o_done.
  - In IDLE: blocks acceptance and MT* writes that cycle.
  - Flush wins over a simultaneous accept.
- i_rst mid-operation: immediate return to reset values at the next edge.

Decomposition:
- Shared package ex_muldiv_pkg holds:
  - funct localparams (FUNCT_MULT … FUNCT_MTLO);
  - state encoding (ST_IDLE, ST_CALC, ST_FIX).
- Add the funct localparams next to the existing ALU funct constants so ALU_Control and this unit agree.
- One sub-module: muldiv_datapath. It holds the iteration registers, the shift-add/restoring step and the sign fix. The top holds the FSM, counter, HI/LO, stall logic and flush handling.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=0x00000003 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; o_done pulses once; o_busy high for exactly 33 cycles.
- DIVU A=100, B=7 → LO=14, HI=2. DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV A=5, B=0 → LO=0xFFFFFFFF, HI=5. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO presented 3 cycles after a MULTU start → o_stall=1 until o_busy drops; the first cycle with o_stall=0 returns the new LO.
- MTHI A=0x12345678, then MFHI next cycle → o_mf_result=0x12345678. MTLO with i_flush=1 → LO unchanged.
- Start MULT, assert i_flush at iteration 10 → IDLE next cycle, HI/LO keep prior values, no o_done; a new DIVU accepted the following cycle completes correctly.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - funct codes and FSM encoding shared by the EX-stage mul/div unit
package ex_muldiv_pkg;

    localparam int NB_FUNCT_PKG = 6;

    // R-type funct codes serviced by the HI/LO unit, kept beside the ALU funct constants
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_MULT  = 6'b011000;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_MULTU = 6'b011001;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_DIV   = 6'b011010;
    localparam logic [NB_FUNCT_PKG-1:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // True for the four iterative operations
    function automatic logic is_muldiv(input logic [NB_FUNCT_PKG-1:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    // True for every code that touches HI/LO and therefore must wait while busy
    function automatic logic is_unit_funct(input logic [NB_FUNCT_PKG-1:0] funct);
        return is_muldiv(funct) ||
               (funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
               (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_datapath.sv
// rtl/ex_muldiv_unit_datapath.sv - iteration registers, shift-add / restoring step and sign fix
module muldiv_datapath #(
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic               i_is_signed,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    // acc holds {partial product, multiplier} or {remainder, dividend->quotient}
    logic [2*NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0]   opnd_q, opnd_d;
    logic [NB_DATA-1:0]   dividend_q, dividend_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic                 div_q, div_d;
    logic                 div_zero_q, div_zero_d;

    logic [NB_DATA-1:0]   mag_a, mag_b;
    logic [NB_DATA:0]     mul_sum;
    logic [NB_DATA:0]     rem_sh;
    logic [NB_DATA:0]     rem_diff;
    logic [2*NB_DATA-1:0] prod_fix;
    logic [NB_DATA-1:0]   quot_fix, rem_fix;

    // Operand capture at accept and one algorithm step per enabled cycle
    always_comb begin
        mag_a      = (i_is_signed && i_a[NB_DATA-1]) ? (~i_a + 1'b1) : i_a;
        mag_b      = (i_is_signed && i_b[NB_DATA-1]) ? (~i_b + 1'b1) : i_b;
        mul_sum    = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh     = acc_q[2*NB_DATA-1:NB_DATA-1];
        rem_diff   = rem_sh - {1'b0, opnd_q};
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        dividend_d = dividend_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        div_d      = div_q;
        div_zero_d = div_zero_q;
        if (i_load) begin
            acc_d      = {{NB_DATA{1'b0}}, mag_a};
            opnd_d     = mag_b;
            dividend_d = i_a;
            neg_q_d    = i_is_signed && (i_a[NB_DATA-1] ^ i_b[NB_DATA-1]);
            neg_r_d    = i_is_signed && i_a[NB_DATA-1];
            div_d      = i_is_div;
            div_zero_d = i_is_div && (i_b == '0);
        end else if (i_step) begin
            if (!div_q) begin
                acc_d = {mul_sum, acc_q[NB_DATA-1:1]};
            end else if (!rem_diff[NB_DATA]) begin
                acc_d = {rem_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
            end else begin
                acc_d = {rem_sh[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
            end
        end
    end

    // Iteration registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            dividend_q <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            dividend_q <= dividend_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            div_q      <= div_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Two's-complement sign correction and HI/LO mapping of the finished result
    always_comb begin
        prod_fix = neg_q_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix = neg_q_q ? (~acc_q[NB_DATA-1:0] + 1'b1) : acc_q[NB_DATA-1:0];
        rem_fix  = neg_r_q ? (~acc_q[2*NB_DATA-1:NB_DATA] + 1'b1) : acc_q[2*NB_DATA-1:NB_DATA];
        if (!div_q) begin
            o_hi = prod_fix[2*NB_DATA-1:NB_DATA];
            o_lo = prod_fix[NB_DATA-1:0];
        end else if (div_zero_q) begin
            o_hi = dividend_q;
            o_lo = '1;
        end else begin
            o_hi = rem_fix;
            o_lo = quot_fix;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/DIV sequencer owning the HI/LO registers
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6,
    parameter int NB_COUNT = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_operand_A,
    input  logic [NB_DATA-1:0]  i_operand_B,
    input  logic                i_flush,
    output logic                o_stall,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_DATA-1:0]  o_mf_result,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo
);

    state_e                state_q, state_d;
    logic [NB_COUNT-1:0]   count_q, count_d;
    logic [NB_DATA-1:0]    hi_q, hi_d;
    logic [NB_DATA-1:0]    lo_q, lo_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  step;
    logic                  is_div_op;
    logic                  is_signed_op;
    logic [NB_DATA-1:0]    res_hi, res_lo;

    muldiv_datapath #(
        .NB_DATA (NB_DATA)
    ) u_datapath (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (accept),
        .i_step      (step),
        .i_is_div    (is_div_op),
        .i_is_signed (is_signed_op),
        .i_a         (i_operand_A),
        .i_b         (i_operand_B),
        .o_hi        (res_hi),
        .o_lo        (res_lo)
    );

    // Next-state, counter, HI/LO writes and datapath control
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        accept       = 1'b0;
        step         = 1'b0;
        is_div_op    = (i_funct == FUNCT_DIV) || (i_funct == FUNCT_DIVU);
        is_signed_op = (i_funct == FUNCT_MULT) || (i_funct == FUNCT_DIV);
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid && !i_flush) begin
                    if (is_muldiv(i_funct)) begin
                        accept  = 1'b1;
                        count_d = NB_COUNT'(NB_DATA - 1);
                        state_d = ST_CALC;
                    end else if (i_funct == FUNCT_MTHI) begin
                        hi_d = i_operand_A;
                    end else if (i_funct == FUNCT_MTLO) begin
                        lo_d = i_operand_A;
                    end
                end
            end
            ST_CALC: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (count_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!i_flush) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, HI/LO and done pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Stall any HI/LO instruction while busy; MF* reads are same-cycle
    always_comb begin
        o_busy      = (state_q != ST_IDLE);
        o_stall     = i_valid && o_busy && is_unit_funct(i_funct);
        o_done      = done_q;
        o_hi        = hi_q;
        o_lo        = lo_q;
        o_mf_result = '0;
        if (i_valid && (i_funct == FUNCT_MFHI)) begin
            o_mf_result = hi_q;
        end else if (i_valid && (i_funct == FUNCT_MFLO)) begin
            o_mf_result = lo_q;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] mf_result, hi, lo;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ex_muldiv_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_funct     (funct),
        .i_operand_A (op_a),
        .i_operand_B (op_b),
        .i_flush     (flush),
        .o_stall     (stall),
        .o_busy      (busy),
        .o_done      (done),
        .o_mf_result (mf_result),
        .o_hi        (hi),
        .o_lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_hi = '0;
        e_lo = '0;
        case (f)
            FUNCT_MULT: begin
                p = 64'(sa * sb);
                e_hi = p[63:32];
                e_lo = p[31:0];
            end
            FUNCT_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e_hi = p[63:32];
                e_lo = p[31:0];
            end
            FUNCT_DIV: begin
                if (b == 0) begin
                    e_hi = a;
                    e_lo = 32'hFFFF_FFFF;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e_lo = 32'(sq);
                    e_hi = 32'(sr);
                end
            end
            default: begin
                if (b == 0) begin
                    e_hi = a;
                    e_lo = 32'hFFFF_FFFF;
                end else begin
                    e_lo = a / b;
                    e_hi = a % b;
                end
            end
        endcase
    endtask

    // Issue one mul/div, then check latency, single done pulse and HI/LO
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] e_hi, e_lo;
        int busy_cycles;
        int early_done;
        model(f, a, b, e_hi, e_lo);
        valid = 1'b1;
        funct = f;
        op_a  = a;
        op_b  = b;
        #1;
        chk({tag, "_accept_stall"}, 32'(stall), 32'd0);
        tick();
        valid = 1'b0;
        busy_cycles = 0;
        early_done  = 0;
        while (busy && busy_cycles < 60) begin
            if (done) early_done++;
            busy_cycles++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        chk({tag, "_early_done"}, 32'(early_done), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hi"}, hi, e_hi);
        chk({tag, "_lo"}, lo, e_lo);
        tick();
        chk({tag, "_done_one_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] e_hi, e_lo, old_hi, old_lo, ra, rb;
        logic [5:0]  rf;
        int          n;

        // Reset state
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        tick();

        // Directed arithmetic cases
        run_op("mult_neg2x3", FUNCT_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_neg2x3_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_neg2x3_lo_const", lo, 32'hFFFF_FFFA);
        run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
        run_op("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        run_op("div_5_0", FUNCT_DIV, 32'd5, 32'd0);
        run_op("divu_0", FUNCT_DIVU, 32'h8000_0001, 32'd0);
        run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", lo, 32'h8000_0000);
        run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Randomized operations against the model
        for (int k = 0; k < 10; k++) begin
            rf = FUNCT_MULT + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op($sformatf("rand%0d", k), rf, ra, rb);
        end

        // MFLO issued three cycles into a MULTU waits for the new LO
        ra = $urandom;
        rb = $urandom;
        model(FUNCT_MULTU, ra, rb, e_hi, e_lo);
        valid = 1'b1;
        funct = FUNCT_MULTU;
        op_a  = ra;
        op_b  = rb;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        valid = 1'b1;
        funct = FUNCT_MFLO;
        #1;
        n = 0;
        while (stall && n < 60) begin
            n++;
            tick();
        end
        chk("mflo_stall_cycles", 32'(n), 32'd30);
        chk("mflo_busy_after", 32'(busy), 32'd0);
        chk("mflo_result", mf_result, e_lo);
        valid = 1'b0;
        tick();

        // MTHI then MFHI
        valid = 1'b1;
        funct = FUNCT_MTHI;
        op_a  = 32'h1234_5678;
        tick();
        funct = FUNCT_MFHI;
        #1;
        chk("mthi_mfhi", mf_result, 32'h1234_5678);
        funct = 6'b100000;
        #1;
        chk("other_funct_mf_zero", mf_result, 32'd0);

        // MTLO blocked by flush
        old_lo = lo;
        funct  = FUNCT_MTLO;
        op_a   = ~old_lo;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        valid  = 1'b0;
        chk("mtlo_flush_lo", lo, old_lo);

        // Flush a MULT at iteration 10, then a DIVU starts right after
        old_hi = hi;
        old_lo = lo;
        valid = 1'b1;
        funct = FUNCT_MULT;
        op_a  = $urandom;
        op_b  = $urandom;
        tick();
        valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_hi", hi, old_hi);
        chk("flush_lo", lo, old_lo);
        run_op("divu_after_flush", FUNCT_DIVU, $urandom, 32'($urandom_range(1, 1000)));

        // Reset mid-operation
        valid = 1'b1;
        funct = FUNCT_DIVU;
        op_a  = 32'd77;
        op_b  = 32'd3;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
